// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   - segment bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} bus
//   - hex_to_seg(): hex nibble to active-high gfedcba pattern
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high pattern, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// ----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider 0..SCAN_DIV-1; tick is high for the single cycle in
// which the divider sits at SCAN_DIV-1 (one tick per digit slot).
// Ports:
//   clk_in   in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   tick     out  one-cycle slot strobe
// ----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int SCAN_DIV = 256
) (
    input  logic clk_in,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] r_div;

    assign tick = (r_div == DIV_W'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common 7-segment digits with a
// tear-free shadow/display register pair: a load is held in the shadow and
// copied to the display only at the frame boundary (index wrap to 0).
// Optional build macro: SEG7_LZB_EN -- blank leading-zero digits (digit 0 is
// never blanked); without it no blanking logic exists.
// Ports:
//   clk_in      in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   value_in    in   4*NUM_DIGITS hex nibbles, digit 0 at [3:0]
//   dp_in       in   decimal point per digit
//   load        in   single-cycle capture strobe
//   pending     out  captured value not yet on display
//   seg_out     out  {dp,g,f,e,d,c,b,a}, registered, polarity SEG_ACTIVE_LOW
//   digit_sel   out  one-hot digit enable, registered, polarity DIGIT_ACTIVE_LOW
//   frame_done  out  one-cycle pulse in the first cycle of each new frame
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 256,
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    pending,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic                    w_tick;
    logic                    w_wrap;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic                    r_frame_done;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digit;

    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_blank;
    logic [7:0]              w_seg_raw;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // Frame boundary: last slot of the last digit.
    assign w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // NOTE: shadow and display are plain registers, not a RAM, so they take the
    // async reset; that is what makes a post-reset frame show all "0".
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else if (load && w_wrap) begin
            // Frame boundary already here: bypass the shadow.
            r_disp_val <= value_in;
            r_disp_dp  <= dp_in;
            r_pending  <= 1'b0;
        end else if (load) begin
            r_shadow_val <= value_in;
            r_shadow_dp  <= dp_in;
            r_pending    <= 1'b1;
        end else if (w_wrap && r_pending) begin
            r_disp_val <= r_shadow_val;
            r_disp_dp  <= r_shadow_dp;
            r_pending  <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        w_sel    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble = r_disp_val[4*k +: 4];
                w_dp     = r_disp_dp[k];
                w_sel[k] = 1'b1;
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] w_lz;
    logic                  w_run;

    // Walk down from the top digit; a digit blanks only while every digit
    // above it is blank too. Digit 0 is never part of the walk.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run   = w_run && (r_disp_val[4*k +: 4] == 4'h0) && !r_disp_dp[k];
            w_lz[k] = w_run;
        end
    end

    assign w_blank = |(w_lz & w_sel);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg_raw              = 8'h00;
        w_seg_raw[SEG_G:SEG_A] = hex_to_seg(w_nibble);
        w_seg_raw[SEG_DP]      = w_dp;
        if (w_blank) begin
            w_seg_raw = 8'h00;
        end
    end

    // Output stage: one cycle behind index/display, polarity applied here.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_seg   <= SEG_OFF;
            r_digit <= DIG_OFF;
        end else begin
            r_seg   <= (SEG_ACTIVE_LOW != 0)   ? ~w_seg_raw : w_seg_raw;
            r_digit <= (DIGIT_ACTIVE_LOW != 0) ? ~w_sel     : w_sel;
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign seg_out    = r_seg;
    assign digit_sel  = r_digit;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4,
// default polarities). Follows SEG7_LZB_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int FRAME = N * SD;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    logic          clk_in;
    logic          reset_n;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          pending;
    logic [7:0]    seg_out;
    logic [3:0]    digit_sel;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges since reset release plus the two value holders.
    int          e;
    logic [15:0] m_disp_val, m_shadow_val;
    logic [3:0]  m_disp_dp, m_shadow_dp;
    bit          m_pend;

    seg7_scan_driver #(
        .NUM_DIGITS       (N),
        .SCAN_DIV         (SD),
        .SEG_ACTIVE_LOW   (0),
        .DIGIT_ACTIVE_LOW (1)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .pending    (pending),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input int dig);
        logic [3:0] nib;
        logic [7:0] s;
        nib = 4'((m_disp_val >> (4 * dig)) & 16'hF);
        s   = SEG_TAB[nib] | (m_disp_dp[dig] ? 8'h80 : 8'h00);
`ifdef SEG7_LZB_EN
        if (dig > 0 && (m_disp_val >> (4 * dig)) == 16'h0 && (m_disp_dp >> dig) == 4'h0)
            s = 8'h00;
`endif
        return s;
    endfunction

    task automatic model_reset();
        e            = 0;
        m_disp_val   = '0;
        m_disp_dp    = '0;
        m_shadow_val = '0;
        m_shadow_dp  = '0;
        m_pend       = 0;
    endtask

    // Called at a negedge: apply inputs for one clock, predict, compare.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
        int         dig;
        bit         wrap;
        logic [7:0] exp_seg;
        logic [3:0] exp_sel;
        load     = ld;
        value_in = v;
        dp_in    = d;
        dig      = (e / SD) % N;
        wrap     = (e % FRAME) == FRAME - 1;
        exp_seg  = model_seg(dig);
        exp_sel  = ~(4'b0001 << dig);
        if (ld && wrap) begin
            m_disp_val = v; m_disp_dp = d; m_pend = 0;
        end else if (ld) begin
            m_shadow_val = v; m_shadow_dp = d; m_pend = 1;
        end else if (wrap && m_pend) begin
            m_disp_val = m_shadow_val; m_disp_dp = m_shadow_dp; m_pend = 0;
        end
        e++;
        @(posedge clk_in);
        @(negedge clk_in);
        load = 1'b0;
        check("seg_out",    32'(seg_out),    32'(exp_seg));
        check("digit_sel",  32'(digit_sel),  32'(exp_sel));
        check("frame_done", 32'(frame_done), 32'(wrap));
        check("pending",    32'(pending),    32'(m_pend));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 16'h0, 4'h0);
    endtask

    // Idle until the next applied step lands on the wrap edge.
    task automatic align_to_wrap();
        while ((e % FRAME) != FRAME - 1) step(0, 16'h0, 4'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},   32'(digit_sel),  32'h0000000F);
        check({tag, "_seg"},   32'(seg_out),    32'h00000000);
        check({tag, "_pend"},  32'(pending),    32'h00000000);
        check({tag, "_frame"}, 32'(frame_done), 32'h00000000);
    endtask

    initial begin
        logic [15:0] rv;
        logic [3:0]  rd;
        reset_n  = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_reset_state("reset");
        reset_n = 1'b1;

        // First post-reset cycle: digit 0 selected showing "0".
        step(0, 16'h0, 4'h0);
        check("first_sel", 32'(digit_sel), 32'h0000000E);
        check("first_seg", 32'(seg_out),   32'h0000003F);
        idle(FRAME + 3);

        // Mid-frame load is held back until the frame boundary.
        step(1, 16'h1A2F, 4'h0);
        check("mid_load_pending", 32'(pending), 32'h1);
        idle(2 * FRAME);

        // Load exactly on the wrap goes straight to the display.
        align_to_wrap();
        step(1, 16'h0008, 4'h0);
        check("wrap_load_pending", 32'(pending), 32'h0);
        step(0, 16'h0, 4'h0);
        check("wrap_load_digit0", 32'(seg_out), 32'h7F);
        idle(FRAME);

        // Leading-zero candidate value.
        align_to_wrap();
        step(1, 16'h0030, 4'h0);
        idle(2 * FRAME);

        // Back-to-back loads while pending: last one wins.
        step(1, 16'h1234, 4'h1);
        step(1, 16'hBEEF, 4'h8);
        idle(2 * FRAME);

        // Randomized traffic with occasional async reset while pending.
        for (int i = 0; i < 600; i++) begin
            rv = 16'($urandom);
            rd = 4'($urandom);
            case ($urandom_range(0, 3))
                0: begin rv &= 16'h00FF; rd &= 4'h3; end
                1: begin rv &= 16'h000F; rd = 4'h0;  end
                default: ;
            endcase
            step($urandom_range(0, 9) == 0, rv, rd);
            if (m_pend && $urandom_range(0, 7) == 0) begin
                #1 reset_n = 1'b0;
                #1 check_reset_state("midrun_reset");
                @(negedge clk_in);
                reset_n = 1'b1;
                model_reset();
                step(0, 16'h0, 4'h0);
                check("post_reset_seg", 32'(seg_out), 32'h3F);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
